// File: rtl/rx_deser_pkg.sv
// Shared types and constants for the serial receive deserializer.
package rx_deser_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2
  } rx_state_t;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam int DATA_WIDTH_MIN = 5;
  localparam int DATA_WIDTH_MAX = 9;

endpackage

// File: rtl/rx_parity_calc.sv
// Combinational parity check: err is high when the received parity bit
// disagrees with the parity expected for data under the selected type.
module rx_parity_calc
  import rx_deser_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  par_typ,
  input  logic                  rx_par,
  output logic                  err
);

  logic exp_par;

  // Odd parity inverts the even-parity bit so the total count of ones is odd.
  assign exp_par = (^data) ^ (par_typ == PAR_ODD);
  assign err     = rx_par ^ exp_par;

endmodule

// File: rtl/rx_deserializer.sv
// Collects strobed serial bits into a parallel word, with optional trailing
// parity bit; publishes each completed frame with a one-cycle valid pulse.
module rx_deserializer
  import rx_deser_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int MSB_FIRST  = 0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  clr,
  input  logic                  bit_vld,
  input  logic                  sampled_bit,
  input  logic                  par_en,
  input  logic                  par_typ,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_valid,
  output logic                  parity_err,
  output logic                  busy
);

  localparam int               CNT_W    = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_WIDTH - 1);

  rx_state_t              state_p0;
  logic [CNT_W-1:0]       cnt_p0;
  logic [DATA_WIDTH-1:0]  shreg_p0;
  logic                   par_en_p0;
  logic                   par_typ_p0;
  logic [DATA_WIDTH-1:0]  p_data_p1;
  logic                   vld_p1;
  logic                   perr_p1;
  logic [DATA_WIDTH-1:0]  shreg_nxt;
  logic                   perr_calc;
  int                     pos;

  // First bit of a frame starts from a clean word so stale bits never leak.
  always_comb begin
    pos       = (state_p0 == ST_IDLE) ? 0 : int'(cnt_p0);
    if (MSB_FIRST != 0) pos = DATA_WIDTH - 1 - pos;
    shreg_nxt = (state_p0 == ST_IDLE) ? '0 : shreg_p0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (i == pos) shreg_nxt[i] = sampled_bit;
    end
  end

  rx_parity_calc #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_parity (
    .data    (shreg_p0),
    .par_typ (par_typ_p0),
    .rx_par  (sampled_bit),
    .err     (perr_calc)
  );

  // p0: frame assembly; p1: published word, flag and completion strobe
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_p0   <= ST_IDLE;
      cnt_p0     <= '0;
      shreg_p0   <= '0;
      par_en_p0  <= 1'b0;
      par_typ_p0 <= 1'b0;
      p_data_p1  <= '0;
      vld_p1     <= 1'b0;
      perr_p1    <= 1'b0;
    end else begin
      vld_p1 <= 1'b0;
      if (clr) begin
        state_p0 <= ST_IDLE;
        cnt_p0   <= '0;
        shreg_p0 <= '0;
      end else if (bit_vld) begin
        case (state_p0)
          ST_IDLE: begin
            shreg_p0   <= shreg_nxt;
            cnt_p0     <= CNT_W'(1);
            par_en_p0  <= par_en;
            par_typ_p0 <= par_typ;
            state_p0   <= ST_DATA;
          end
          ST_DATA: begin
            shreg_p0 <= shreg_nxt;
            if (cnt_p0 == LAST_IDX) begin
              cnt_p0 <= '0;
              if (par_en_p0) begin
                state_p0 <= ST_PARITY;
              end else begin
                state_p0  <= ST_IDLE;
                p_data_p1 <= shreg_nxt;
                perr_p1   <= 1'b0;
                vld_p1    <= 1'b1;
              end
            end else begin
              cnt_p0 <= cnt_p0 + CNT_W'(1);
            end
          end
          ST_PARITY: begin
            state_p0  <= ST_IDLE;
            p_data_p1 <= shreg_p0;
            perr_p1   <= perr_calc;
            vld_p1    <= 1'b1;
          end
          default: begin
            state_p0 <= ST_IDLE;
            cnt_p0   <= '0;
          end
        endcase
      end
    end
  end

  assign P_DATA     = p_data_p1;
  assign data_valid = vld_p1;
  assign parity_err = perr_p1;
  assign busy       = (state_p0 != ST_IDLE);

endmodule

// File: tb/tb_rx_deserializer.sv
// Directed bench for rx_deserializer: an 8-bit LSB-first and a 7-bit MSB-first
// instance share stimulus; each scenario task checks its own results.
module tb_rx_deserializer;

  logic       CLK, RST, clr, bit_vld, sampled_bit, par_en, par_typ;
  logic [7:0] pd8;
  logic [6:0] pd7;
  logic       dv8, pe8, bz8, dv7, pe7, bz7;

  int         n_chk  = 0;
  int         n_pass = 0;
  int         dv8_cnt = 0;
  int         dv7_cnt = 0;
  logic [7:0] q8[$];

  rx_deserializer #(.DATA_WIDTH(8), .MSB_FIRST(0)) dut8 (
    .CLK(CLK), .RST(RST), .clr(clr), .bit_vld(bit_vld), .sampled_bit(sampled_bit),
    .par_en(par_en), .par_typ(par_typ), .P_DATA(pd8), .data_valid(dv8),
    .parity_err(pe8), .busy(bz8));

  rx_deserializer #(.DATA_WIDTH(7), .MSB_FIRST(1)) dut7 (
    .CLK(CLK), .RST(RST), .clr(clr), .bit_vld(bit_vld), .sampled_bit(sampled_bit),
    .par_en(par_en), .par_typ(par_typ), .P_DATA(pd7), .data_valid(dv7),
    .parity_err(pe7), .busy(bz7));

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Record every completion pulse once, just after the edge that raised it.
  always @(posedge CLK) begin
    #1;
    if (dv8) begin
      dv8_cnt++;
      q8.push_back(pd8);
    end
    if (dv7) dv7_cnt++;
  end

  // Drives n data bits (d[0] first) with contiguous strobes, then an optional
  // parity bit. par_en/par_typ are inverted after the first bit to prove they
  // are latched per frame. clr_last raises clr with the final strobe.
  task automatic send_frame(input logic [8:0] d, input int n, input logic pen,
                            input logic ptyp, input logic pbit,
                            input bit clr_last, input bit hold);
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      bit_vld     = 1'b1;
      sampled_bit = d[i];
      clr         = clr_last && !pen && (i == n - 1);
      if (i == 0) begin
        par_en  = pen;
        par_typ = ptyp;
      end else if (i == 1) begin
        par_en  = ~pen;
        par_typ = ~ptyp;
      end
    end
    if (pen) begin
      @(negedge CLK);
      sampled_bit = pbit;
      clr         = clr_last;
    end
    if (!hold) begin
      @(negedge CLK);
      bit_vld = 1'b0;
      clr     = 1'b0;
    end
  endtask

  task automatic test_reset;
    RST = 1'b0;
    repeat (2) @(negedge CLK);
    n_chk++; if (pd8 !== 8'h00) $display("FAIL reset_pdata: got %h want 00", pd8); else n_pass++;
    n_chk++; if (dv8 !== 1'b0) $display("FAIL reset_dvalid: got %b want 0", dv8); else n_pass++;
    n_chk++; if (pe8 !== 1'b0) $display("FAIL reset_perr: got %b want 0", pe8); else n_pass++;
    n_chk++; if (bz8 !== 1'b0) $display("FAIL reset_busy: got %b want 0", bz8); else n_pass++;
    n_chk++; if (pd7 !== 7'h00) $display("FAIL reset_pdata7: got %h want 00", pd7); else n_pass++;
    RST = 1'b1;
  endtask

  task automatic test_basic;
    int c0;
    c0 = dv8_cnt;
    send_frame(9'h0A5, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_chk++; if (dv8 !== 1'b1) $display("FAIL basic_dvalid: got %b want 1", dv8); else n_pass++;
    n_chk++; if (dv8_cnt !== c0 + 1) $display("FAIL basic_latency: pulses %0d want %0d", dv8_cnt - c0, 1); else n_pass++;
    n_chk++; if (pd8 !== 8'hA5) $display("FAIL basic_pdata: got %h want a5", pd8); else n_pass++;
    n_chk++; if (pe8 !== 1'b0) $display("FAIL basic_perr: got %b want 0", pe8); else n_pass++;
    @(negedge CLK);
    n_chk++; if (dv8 !== 1'b0) $display("FAIL basic_pulse_width: got %b want 0", dv8); else n_pass++;
    n_chk++; if (bz8 !== 1'b0) $display("FAIL basic_busy_idle: got %b want 0", bz8); else n_pass++;
    repeat (3) @(negedge CLK);
    n_chk++; if (pd8 !== 8'hA5) $display("FAIL basic_hold: got %h want a5", pd8); else n_pass++;
    n_chk++; if (dv8_cnt !== c0 + 1) $display("FAIL basic_single_pulse: pulses %0d want 1", dv8_cnt - c0); else n_pass++;
  endtask

  task automatic test_parity_even;
    int c0;
    c0 = dv8_cnt;
    send_frame(9'h037, 8, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    n_chk++; if (dv8_cnt !== c0 + 1) $display("FAIL even_pulses: got %0d want 1", dv8_cnt - c0); else n_pass++;
    n_chk++; if (pd8 !== 8'h37) $display("FAIL even_pdata: got %h want 37", pd8); else n_pass++;
    n_chk++; if (pe8 !== 1'b0) $display("FAIL even_ok_perr: got %b want 0", pe8); else n_pass++;
    send_frame(9'h037, 8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    n_chk++; if (dv8 !== 1'b1) $display("FAIL even_bad_dvalid: got %b want 1", dv8); else n_pass++;
    n_chk++; if (pe8 !== 1'b1) $display("FAIL even_bad_perr: got %b want 1", pe8); else n_pass++;
  endtask

  task automatic test_parity_odd;
    send_frame(9'h037, 8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    n_chk++; if (pe8 !== 1'b0) $display("FAIL odd_ok_perr: got %b want 0", pe8); else n_pass++;
    send_frame(9'h037, 8, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    n_chk++; if (pe8 !== 1'b1) $display("FAIL odd_bad_perr: got %b want 1", pe8); else n_pass++;
    repeat (3) @(negedge CLK);
    n_chk++; if (pe8 !== 1'b1) $display("FAIL odd_perr_hold: got %b want 1", pe8); else n_pass++;
    n_chk++; if (pd8 !== 8'h37) $display("FAIL odd_pdata_hold: got %h want 37", pd8); else n_pass++;
  endtask

  task automatic test_clr;
    int c0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      bit_vld = 1'b1; sampled_bit = 1'b1; par_en = 1'b0;
    end
    @(negedge CLK); bit_vld = 1'b0;
    n_chk++; if (bz8 !== 1'b1) $display("FAIL clr_busy_partial: got %b want 1", bz8); else n_pass++;
    clr = 1'b1;
    @(negedge CLK); clr = 1'b0;
    n_chk++; if (bz8 !== 1'b0) $display("FAIL clr_busy_after: got %b want 0", bz8); else n_pass++;
    n_chk++; if (pd8 !== 8'h37) $display("FAIL clr_pdata_held: got %h want 37", pd8); else n_pass++;
    n_chk++; if (pe8 !== 1'b1) $display("FAIL clr_perr_held: got %b want 1", pe8); else n_pass++;
    c0 = dv8_cnt;
    send_frame(9'h03C, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_chk++; if (dv8_cnt !== c0 + 1) $display("FAIL clr_restart_pulses: got %0d want 1", dv8_cnt - c0); else n_pass++;
    n_chk++; if (pd8 !== 8'h3C) $display("FAIL clr_restart_pdata: got %h want 3c", pd8); else n_pass++;
    c0 = dv8_cnt;
    send_frame(9'h0FF, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    n_chk++; if (dv8 !== 1'b0) $display("FAIL clr_on_last_dvalid: got %b want 0", dv8); else n_pass++;
    n_chk++; if (dv8_cnt !== c0) $display("FAIL clr_on_last_pulses: got %0d want 0", dv8_cnt - c0); else n_pass++;
    n_chk++; if (pd8 !== 8'h3C) $display("FAIL clr_on_last_pdata: got %h want 3c", pd8); else n_pass++;
    n_chk++; if (bz8 !== 1'b0) $display("FAIL clr_on_last_busy: got %b want 0", bz8); else n_pass++;
  endtask

  task automatic test_msb_first;
    int c7;
    @(negedge CLK); RST = 1'b0;
    @(negedge CLK); RST = 1'b1;
    c7 = dv7_cnt;
    send_frame(9'h041, 7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_chk++; if (dv7_cnt !== c7 + 1) $display("FAIL msb_pulses: got %0d want 1", dv7_cnt - c7); else n_pass++;
    n_chk++; if (pd7 !== 7'h41) $display("FAIL msb_pdata_41: got %h want 41", pd7); else n_pass++;
    n_chk++; if (pe7 !== 1'b0) $display("FAIL msb_perr: got %b want 0", pe7); else n_pass++;
    send_frame(9'h003, 7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_chk++; if (pd7 !== 7'h60) $display("FAIL msb_pdata_60: got %h want 60", pd7); else n_pass++;
  endtask

  task automatic test_back_to_back;
    logic [7:0] got0, got1;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      bit_vld = 1'b1; sampled_bit = 1'b1; par_en = 1'b0;
    end
    @(negedge CLK); bit_vld = 1'b0;
    #2 RST = 1'b0;
    #1;
    n_chk++; if (bz8 !== 1'b0) $display("FAIL rst_async_busy: got %b want 0", bz8); else n_pass++;
    n_chk++; if (pd8 !== 8'h00) $display("FAIL rst_async_pdata: got %h want 00", pd8); else n_pass++;
    @(negedge CLK); RST = 1'b1;
    q8.delete();
    send_frame(9'h081, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    send_frame(9'h07E, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_chk++; if (dv8 !== 1'b1) $display("FAIL b2b_dvalid: got %b want 1", dv8); else n_pass++;
    n_chk++; if (pd8 !== 8'h7E) $display("FAIL b2b_pdata_last: got %h want 7e", pd8); else n_pass++;
    @(negedge CLK);
    got0 = (q8.size() > 0) ? q8[0] : 8'hxx;
    got1 = (q8.size() > 1) ? q8[1] : 8'hxx;
    n_chk++; if (q8.size() !== 2) $display("FAIL b2b_pulses: got %0d want 2", q8.size()); else n_pass++;
    n_chk++; if (got0 !== 8'h81) $display("FAIL b2b_first: got %h want 81", got0); else n_pass++;
    n_chk++; if (got1 !== 8'h7E) $display("FAIL b2b_second: got %h want 7e", got1); else n_pass++;
  endtask

  initial begin
    RST = 1'b0; clr = 1'b0; bit_vld = 1'b0; sampled_bit = 1'b0;
    par_en = 1'b0; par_typ = 1'b0;
    test_reset();
    test_basic();
    test_parity_even();
    test_parity_odd();
    test_clr();
    test_msb_first();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
